inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Instruction store for the single-cycle MIPS sort CPU, sitting directly upstream of the program counter. It accepts a program as a byte stream over a valid/ready port and packs it big-endian into a 256×32 instruction RAM. Once loading finishes it raises `over` to release the PC. During execution it returns `inst = mem[PC]` combinationally, so each instruction is available in the same cycle its address is presented.

## Interface
- `DEPTH`, 256: instruction words. Must equal 2^8 to match the 8-bit PC.
- `Clk`  in  1  system clock, rising edge.
- `Clr`  in  1  reset; asynchronous, active-high.
- `ld_valid`  in  1  loader byte valid.
- `ld_byte`  in  8  loader byte. Big-endian: the first byte of each word goes to bits [31:24].
- `ld_last`  in  1  qualifies the final byte of the program.
- `ld_ready`  out  1  block can accept a byte.
- `PC`  in  8  fetch address from the PC stage.
- `inst`  out  32  instruction at `PC`.
- `over`  out  1  program loaded; the PC may run.
- `load_cnt`  out  9  words written, 0..256.
- `err`  out  1  sticky load error.

## Operation
- **States:** IDLE, LOAD, DONE. Reset state is IDLE.
- **Transfer rule:** a byte transfers on a rising `Clk` when `ld_valid && ld_ready`.
- **`ld_ready`:** 1 in IDLE and LOAD, 0 in DONE.
- **IDLE → LOAD:** on the first transfer. That byte is processed as a normal load byte.
- **Byte assembly:** a 2-bit byte index `bi` and a 24-bit shift register collect the bytes of a word.
  - When the byte with `bi==3` transfers, the full word is written to `mem[load_cnt[7:0]]`.
  - On that same edge, `load_cnt` increments.
- **Transfer with `ld_last`:**
  - If `bi==3`: normal write, then go to DONE.
  - If `bi!=3`: the partial word is written with the missing low bytes zero-filled, `load_cnt` increments, `err` is set, then go to DONE.
  - `ld_last` arriving in IDLE, i.e. a 1-byte program: write `{byte, 24'h0}`, set `err`, go to DONE.
- **Overflow:** when `load_cnt==256`, further bytes are accepted and discarded, with no write. `err` is set. The FSM still waits for `ld_last`.
- **DONE:**
  - `over=1`.
  - Inputs on the load port are ignored.
  - Leaving DONE requires `Clr`.
- **Fetch:**
  - `inst = over ? mem[PC] : 32'h0`. Before `over`, `inst` is a NOP, so the PC sees harmless instructions.
  - Fetch is purely combinational from `PC` and `over`.
- **Memory contents:** not cleared by `Clr`. Words that were never written read as X in simulation. The bench must load every word it executes.

## Timing
- **Reset values:**
  - state=IDLE, `ld_ready=1`, `over=0`, `load_cnt=0`, `err=0`, `bi=0`.
  - `inst=0`, because `over=0`.
- **Write timing:** a RAM write and the `load_cnt` update happen on the edge that accepts byte 3 of the word.
- **`over` timing:** `over` rises on the edge that accepts the `ld_last` byte. The final word is already written on that edge, so `inst` is valid in the same cycle `over` is seen.
- **Throughput:** one byte per cycle. No bubbles required.
- **Clr mid-load:** state returns to IDLE immediately and the partial word is lost. RAM keeps the words written so far.
- **Clr during DONE:** `over` drops asynchronously. The PC, which shares `Clr`, also clears.
- **Simultaneous `ld_last` and overflow:** byte discarded, `err=1`, go to DONE.

## Configuration
- **`INST_MEM_CKSUM_EN` defined:**
  - Adds input `ld_cksum[7:0]` and output `cksum[7:0]`.
  - `cksum` is the running XOR of all accepted bytes, including discarded overflow bytes, and resets to 0.
  - On the `ld_last` transfer, the final XOR (including that byte) is compared with `ld_cksum`. A mismatch sets `err`.
  - `over` still asserts regardless of the comparison result.
- **`INST_MEM_CKSUM_EN` undefined:** no checksum ports, no checksum logic, and `err` covers only partial-word and overflow errors.

## Test plan
- **Normal load:** Clr, then bytes 20,08,00,05, 20,09,00,07 (the 2nd with `ld_last`).
  - Required: `load_cnt=2`, `over=1` on the last edge, `err=0`.
  - PC=0 → inst=32'h20080005; PC=1 → inst=32'h20090007.
- **Pre-load NOP:** before any load, drive PC=8'h05 → inst=0 and `over=0`.
- **Partial word:** bytes AA,BB,CC with `ld_last` on CC.
  - Required: `mem[0]=32'hAABBCC00`, `load_cnt=1`, `err=1`, `over=1`.
- **Overflow:** 257 full words streamed with `ld_last` on the final byte.
  - Required: `load_cnt=256`, `err=1`, `mem[0]` not overwritten by word 257.
- **Reset mid-load:** pulse Clr after 6 bytes.
  - Required: `ld_ready=1`, `load_cnt=0`, `over=0`, `mem[0]` retained.
  - Reload of 1 word then succeeds.
- **Backpressure and DONE (with `INST_MEM_CKSUM_EN`):**
  - `ld_valid` gaps inside a word do not corrupt it.
  - Once DONE, `ld_ready=0` and extra bytes are ignored.
  - Wrong `ld_cksum` → `err=1`.

Source files
------------

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: instruction store for the single-cycle MIPS sort CPU.
// Takes a program as a byte stream over a valid/ready port and packs it
// big-endian into a 256x32 RAM, then raises `over` to release the PC.
// Fetch is combinational: inst = over ? mem[PC] : 0 (a NOP before the load
// completes).
// Optional feature: define INST_MEM_CKSUM_EN to add the ld_cksum/cksum
// running-XOR checksum check on the final byte.
module inst_mem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
`ifdef INST_MEM_CKSUM_EN
  input  logic [7:0]  ld_cksum,
  output logic [7:0]  cksum,
`endif
  input  logic [7:0]  PC,
  output logic [31:0] inst,
  output logic        over,
  output logic [8:0]  load_cnt,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_bi;
  logic [1:0]  w_bi_next;
  logic [23:0] r_shift;
  logic [23:0] w_shift_next;
  logic [8:0]  r_load_cnt;
  logic [8:0]  w_cnt_next;
  logic        r_err;
  logic        w_err_next;
  logic        w_xfer;
  logic        w_we;
  logic [31:0] w_word;
  logic [31:0] r_mem [DEPTH];

  assign w_xfer   = ld_valid && ld_ready;
  assign ld_ready = (r_state != DONE);
  assign over     = (r_state == DONE);
  assign load_cnt = r_load_cnt;
  assign err      = r_err;
  // Fetch must be same-cycle for the single-cycle CPU, so the read is not registered.
  assign inst     = over ? r_mem[PC] : 32'h0;

`ifdef INST_MEM_CKSUM_EN
  logic [7:0] r_cksum;
  logic       w_cksum_bad;

  assign cksum       = r_cksum;
  assign w_cksum_bad = ((r_cksum ^ ld_byte) != ld_cksum);

  // Running XOR of every accepted byte, overflow bytes included.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)         r_cksum <= 8'h00;
    else if (w_xfer) r_cksum <= r_cksum ^ ld_byte;
  end
`else
  logic w_cksum_bad;
  assign w_cksum_bad = 1'b0;
`endif

  // Word to write: complete word on byte 3, otherwise partial word zero-filled below.
  always_comb begin
    w_word = 32'h0;
    case (r_bi)
      2'd0:    w_word = {ld_byte, 24'h0};
      2'd1:    w_word = {r_shift[7:0], ld_byte, 16'h0};
      2'd2:    w_word = {r_shift[15:0], ld_byte, 8'h0};
      default: w_word = {r_shift, ld_byte};
    endcase
  end

  // Next-state, byte assembly, write enable and error logic.
  always_comb begin
    w_state_next = r_state;
    w_bi_next    = r_bi;
    w_shift_next = r_shift;
    w_cnt_next   = r_load_cnt;
    w_err_next   = r_err;
    w_we         = 1'b0;
    if (w_xfer) begin
      w_state_next = ld_last ? DONE : LOAD;
      if (r_load_cnt[8]) begin
        // RAM full: accept and drop the byte, flag the overflow.
        w_err_next = 1'b1;
      end else if ((r_bi == 2'd3) || ld_last) begin
        w_we       = 1'b1;
        w_cnt_next = r_load_cnt + 9'd1;
        w_bi_next  = 2'd0;
        w_shift_next = 24'h0;
        if (r_bi != 2'd3) w_err_next = 1'b1;
      end else begin
        w_bi_next    = r_bi + 2'd1;
        w_shift_next = {r_shift[15:0], ld_byte};
      end
      if (ld_last && w_cksum_bad) w_err_next = 1'b1;
    end
  end

  // Control registers; Clr drops the load mid-word and releases DONE.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state    <= IDLE;
      r_bi       <= 2'd0;
      r_shift    <= 24'h0;
      r_load_cnt <= 9'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bi       <= w_bi_next;
      r_shift    <= w_shift_next;
      r_load_cnt <= w_cnt_next;
      r_err      <= w_err_next;
    end
  end

  // Instruction RAM write port; contents survive Clr.
  always_ff @(posedge Clk) begin
    if (w_we) r_mem[r_load_cnt[7:0]] <= w_word;
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: self-checking bench for inst_mem_loader. Expected
// (address, word) pairs are queued as bytes are driven and checked through
// the fetch port once the load completes. Checksum checks are compiled in
// when INST_MEM_CKSUM_EN is defined.
module tb_inst_mem_loader;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [7:0]  PC = 8'h00;
  logic [31:0] inst;
  logic        over;
  logic [8:0]  load_cnt;
  logic        err;
  logic [7:0]  ld_cksum = 8'h00;
`ifdef INST_MEM_CKSUM_EN
  logic [7:0]  cksum;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  inst_mem_loader dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
`ifdef INST_MEM_CKSUM_EN
    .ld_cksum (ld_cksum),
    .cksum    (cksum),
`endif
    .PC       (PC),
    .inst     (inst),
    .over     (over),
    .load_cnt (load_cnt),
    .err      (err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ovf_word(input int i);
    logic [15:0] v;
    v = i[15:0];
    return {v ^ 16'h5A00, ~v};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge Clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    @(posedge Clk);
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_byte  = 8'hFF;
      @(posedge Clk);
    end
  endtask

  task automatic end_stream();
    @(negedge Clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge Clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      PC = e.addr;
      #1;
      checks++;
      if (inst !== e.data) begin
        errors++;
        $display("FAIL %s fetch PC=%02h: got %08h expected %08h", tag, e.addr, inst, e.data);
      end else begin
        $display("%s fetch PC=%02h inst=%08h", tag, e.addr, inst);
      end
    end
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    repeat (2) @(negedge Clk);
    Clr = 1'b0;
    PC = 8'h05;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset ld_ready: got %b expected 1", ld_ready); end
    checks++;
    if (over !== 1'b0) begin errors++; $display("FAIL reset over: got %b expected 0", over); end
    checks++;
    if (load_cnt !== 9'd0) begin errors++; $display("FAIL reset load_cnt: got %0d expected 0", load_cnt); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b expected 0", err); end
    checks++;
    if (inst !== 32'h0) begin errors++; $display("FAIL preload_nop inst: got %08h expected 00000000", inst); end
    $display("reset: ld_ready=%b over=%b load_cnt=%0d err=%b inst=%08h", ld_ready, over, load_cnt, err, inst);
  endtask

  task automatic test_normal_load();
    logic [7:0] bytes [8];
    bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    sb.push_back('{8'd0, 32'h20080005});
    sb.push_back('{8'd1, 32'h20090007});
    for (int k = 0; k < 8; k++) begin
      send_byte(bytes[k], k == 7);
      if (k == 3) begin
        #1;
        checks++;
        if (load_cnt !== 9'd1 || over !== 1'b0) begin
          errors++;
          $display("FAIL normal word0 write: got load_cnt=%0d over=%b expected 1/0", load_cnt, over);
        end
      end
    end
    #1;
    checks++;
    if (over !== 1'b1) begin errors++; $display("FAIL normal over on last edge: got %b expected 1", over); end
    end_stream();
    checks++;
    if (load_cnt !== 9'd2) begin errors++; $display("FAIL normal load_cnt: got %0d expected 2", load_cnt); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL normal err: got %b expected 0", err); end
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL normal ld_ready in DONE: got %b expected 0", ld_ready); end
    drain("normal");
  endtask

  task automatic test_partial();
    pulse_clr();
    sb.push_back('{8'd0, 32'hAABBCC00});
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    end_stream();
    checks++;
    if (load_cnt !== 9'd1) begin errors++; $display("FAIL partial load_cnt: got %0d expected 1", load_cnt); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL partial err: got %b expected 1", err); end
    checks++;
    if (over !== 1'b1) begin errors++; $display("FAIL partial over: got %b expected 1", over); end
    drain("partial");
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    pulse_clr();
    for (int i = 0; i <= 256; i++) begin
      w = ovf_word(i);
      if (i < 256) sb.push_back('{i[7:0], w});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31-8*k -: 8], (i == 256) && (k == 3));
      end
      if (i == 255) begin
        #1;
        checks++;
        if (load_cnt !== 9'd256 || err !== 1'b0 || over !== 1'b0) begin
          errors++;
          $display("FAIL overflow full: got load_cnt=%0d err=%b over=%b expected 256/0/0", load_cnt, err, over);
        end
      end
    end
    end_stream();
    checks++;
    if (load_cnt !== 9'd256) begin errors++; $display("FAIL overflow load_cnt: got %0d expected 256", load_cnt); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL overflow err: got %b expected 1", err); end
    checks++;
    if (over !== 1'b1) begin errors++; $display("FAIL overflow over: got %b expected 1", over); end
    drain("overflow");
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulse_clr();
    for (int k = 0; k < 6; k++) send_byte(bytes[k], 1'b0);
    @(negedge Clk);
    ld_valid = 1'b0;
    Clr = 1'b1;
    #1;
    checks++;
    if (over !== 1'b0 || ld_ready !== 1'b1 || load_cnt !== 9'd0) begin
      errors++;
      $display("FAIL midload clr: got over=%b ld_ready=%b load_cnt=%0d expected 0/1/0", over, ld_ready, load_cnt);
    end
    @(negedge Clk);
    Clr = 1'b0;
    sb.push_back('{8'd0, 32'h778899AA});
    sb.push_back('{8'd1, ovf_word(1)});
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'hAA, 1'b1);
    end_stream();
    checks++;
    if (load_cnt !== 9'd1 || err !== 1'b0 || over !== 1'b1) begin
      errors++;
      $display("FAIL midload reload: got load_cnt=%0d err=%b over=%b expected 1/0/1", load_cnt, err, over);
    end
    drain("midload");
  endtask

  task automatic test_backpressure_done();
    logic [7:0] bytes [8];
    logic [7:0] x;
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    x = 8'h00;
    for (int k = 0; k < 8; k++) x = x ^ bytes[k];
    ld_cksum = x;
    pulse_clr();
    sb.push_back('{8'd0, 32'hDEADBEEF});
    sb.push_back('{8'd1, 32'h01020304});
    sb.push_back('{8'd2, ovf_word(2)});
    for (int k = 0; k < 8; k++) begin
      send_byte(bytes[k], k == 7);
      if (k < 7) gap(k % 3 + 1);
    end
    end_stream();
    checks++;
    if (load_cnt !== 9'd2 || err !== 1'b0 || over !== 1'b1) begin
      errors++;
      $display("FAIL backpressure load: got load_cnt=%0d err=%b over=%b expected 2/0/1", load_cnt, err, over);
    end
`ifdef INST_MEM_CKSUM_EN
    checks++;
    if (cksum !== x) begin errors++; $display("FAIL cksum value: got %02h expected %02h", cksum, x); end
`endif
    for (int k = 0; k < 3; k++) send_byte(8'hC0 + k[7:0], k == 2);
    end_stream();
    checks++;
    if (ld_ready !== 1'b0 || load_cnt !== 9'd2 || err !== 1'b0 || over !== 1'b1) begin
      errors++;
      $display("FAIL done ignore: got ld_ready=%b load_cnt=%0d err=%b over=%b expected 0/2/0/1",
               ld_ready, load_cnt, err, over);
    end
    drain("backpressure");
`ifdef INST_MEM_CKSUM_EN
    ld_cksum = x ^ 8'h5A;
    pulse_clr();
    for (int k = 0; k < 8; k++) send_byte(bytes[k], k == 7);
    end_stream();
    checks++;
    if (err !== 1'b1 || over !== 1'b1 || load_cnt !== 9'd2) begin
      errors++;
      $display("FAIL cksum wrong: got err=%b over=%b load_cnt=%0d expected 1/1/2", err, over, load_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_partial();
    test_overflow();
    test_reset_mid_load();
    test_backpressure_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
